// File: rtl/rorg_check_pkg.sv
// -----------------------------------------------------------------------------
// rorg_check_pkg
// Shared definitions for the response checker: FSM state encoding and the
// MISR polynomial/seed constants used by misr16.
// -----------------------------------------------------------------------------
package rorg_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // x^16 + x^12 + x^5 + 1 (the x^16 term is implicit in the shift-out bit)
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/resp_checker_misr16.sv
// -----------------------------------------------------------------------------
// misr16
// 16-bit multiple-input signature register, polynomial x^16+x^12+x^5+1.
// Each shift moves the register left by one, folds the shifted-out bit back
// through the polynomial, and XORs the 2-bit input into bits [1:0].
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset (loads the seed)
//   clear     in   reload the seed
//   shift_en  in   shift once, absorbing din
//   din[1:0]  in   data folded into the feedback word
//   sig[15:0] out  current signature
// -----------------------------------------------------------------------------
module misr16
    import rorg_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [1:0]  din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = MISR_SEED;
        end else if (shift_en) begin
            sig_d = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                  ^ {14'h0000, din};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/resp_checker.sv
// -----------------------------------------------------------------------------
// resp_checker
// Observes the two outputs (x, y) of a combinational DUT once per stimulus
// step and compares them against a compiled-in expected table. Reports
// pass/fail, a saturating mismatch count, the first failing step and an
// idle timeout.
//
// Optional feature macro: RESP_CHECKER_MISR_EN
//   defined   -> a 16-bit MISR compacts every accepted sample into signature
//   undefined -> signature is tied to 16'h0000, no MISR logic
//
// Handshake: a sample is accepted on a rising edge where
// sample_valid && sample_ready; sample_ready is high exactly while in RUN,
// independent of sample_valid.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      one-cycle arm pulse (honoured in IDLE/DONE)
//   sample_valid/sample_ready  sample handshake
//   sample_x, sample_y         DUT outputs being checked
//   busy, done, pass, timeout  status
//   err_count                  saturating mismatch count
//   first_err_valid/_idx       first mismatching step
//   step_idx                   samples accepted in this run
//   signature                  MISR signature (or zero)
// -----------------------------------------------------------------------------
module resp_checker
    import rorg_check_pkg::*;
#(
    parameter int                       NUM_STEPS = 10,
    parameter logic [2*NUM_STEPS-1:0]   EXPECTED  = '0,
    parameter int                       TIMEOUT   = 1000,
    parameter int                       IDX_W     = 4,
    parameter int                       CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             sample_x,
    input  logic             sample_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [IDX_W-1:0] step_idx,
    output logic [15:0]      signature
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0]  MAX_STEP  = IDX_W'(NUM_STEPS);

    // FSM state; kept as a named signal so checkers can bind to it.
    state_e state_q;
    state_e state_d;

    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;
    logic              first_err_valid_q;
    logic              first_err_valid_d;
    logic [IDX_W-1:0]  first_err_idx_q;
    logic [IDX_W-1:0]  first_err_idx_d;
    logic [IDX_W-1:0]  step_idx_q;
    logic [IDX_W-1:0]  step_idx_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              timeout_q;
    logic              timeout_d;

    logic                   accept;
    logic                   arm;
    logic                   idle_expired;
    logic                   mismatch;
    logic [2*NUM_STEPS-1:0] exp_shifted;
    logic [1:0]             exp_pair;

    assign accept       = sample_valid && (state_q == RUN);
    assign arm          = start && (state_q != RUN);
    // Only counts as a timeout if no sample arrives in the same cycle.
    assign idle_expired = (state_q == RUN) && !accept && (idle_q == IDLE_LAST);

    // Shifting avoids a variable-width part-select into the table.
    assign exp_shifted = EXPECTED >> {step_idx_q, 1'b0};
    assign exp_pair    = exp_shifted[1:0];
    assign mismatch    = ({sample_x, sample_y} != exp_pair);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (accept && (step_idx_q == LAST_STEP)) begin
                    state_d = DONE;
                end else if (idle_expired) begin
                    state_d = DONE;
                end
            end
            DONE: if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sample_ready = (state_q == RUN);
        busy         = (state_q == RUN);
        done         = (state_q == DONE);
        pass         = (state_q == DONE) && (err_count_q == '0) && !timeout_q;
    end

    // ---------------- Result datapath ----------------
    always_comb begin
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        step_idx_d        = step_idx_q;
        idle_d            = idle_q;
        timeout_d         = timeout_q;

        if (arm) begin
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_idx_d   = '0;
            step_idx_d        = '0;
            idle_d            = '0;
            timeout_d         = 1'b0;
        end else if (accept) begin
            idle_d = '0;
            if (step_idx_q != MAX_STEP) begin
                step_idx_d = step_idx_q + 1'b1;
            end
            if (mismatch) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + 1'b1;
                end
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_idx_d   = step_idx_q;
                end
            end
        end else if (idle_expired) begin
            timeout_d = 1'b1;
        end else if (state_q == RUN) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            step_idx_q        <= '0;
            idle_q            <= '0;
            timeout_q         <= 1'b0;
        end else begin
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            step_idx_q        <= step_idx_d;
            idle_q            <= idle_d;
            timeout_q         <= timeout_d;
        end
    end

    assign timeout         = timeout_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign step_idx        = step_idx_q;

`ifdef RESP_CHECKER_MISR_EN
    misr16 u_misr (
        .clk      (clk),
        .reset    (reset),
        .clear    (arm),
        .shift_en (accept),
        .din      ({sample_x, sample_y}),
        .sig      (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_resp_checker
// Self-checking bench for resp_checker. A behavioural model tracks the
// expected result of each run from the table rules; scenario tasks compare
// the DUT against it.
// -----------------------------------------------------------------------------
module tb_resp_checker;

    localparam int          NSTEP   = 10;
    localparam int          TMO     = 8;
    localparam int          IW      = 4;
    localparam int          CW      = 2;
    localparam logic [19:0] EXP_TAB = 20'h9C6B3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          sample_x = 1'b0;
    logic          sample_y = 1'b0;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] err_count;
    logic          first_err_valid;
    logic [IW-1:0] first_err_idx;
    logic [IW-1:0] step_idx;
    logic [15:0]   signature;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model state ----------------
    logic [19:0] exp_tab;
    int          m_step;
    int          m_err;
    bit          m_first_v;
    int          m_first;
    logic [15:0] m_sig;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    resp_checker #(
        .NUM_STEPS (NSTEP),
        .EXPECTED  (EXP_TAB),
        .TIMEOUT   (TMO),
        .IDX_W     (IW),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .sample_x        (sample_x),
        .sample_y        (sample_y),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .step_idx        (step_idx),
        .signature       (signature)
    );

    // ---------------- model helpers ----------------
    function automatic logic [1:0] exp_pair(input int k);
        logic [19:0] t;
        t = exp_tab >> (2 * k);
        return t[1:0];
    endfunction

    function automatic logic [15:0] sig_after_reset();
`ifdef RESP_CHECKER_MISR_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    // Expected signature as the DUT should report it (zero without the MISR).
    function automatic logic [15:0] sig_expected();
`ifdef RESP_CHECKER_MISR_EN
        return m_sig;
`else
        return 16'h0000;
`endif
    endfunction

    // Polynomial division step: multiply by x mod P, then add the sample.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
        logic [16:0] w;
        w = {s, 1'b0};
        if (w[16]) w = w ^ 17'h11021;
        return w[15:0] ^ {14'h0, d};
    endfunction

    function automatic int sat_err(input int e);
        return (e > 3) ? 3 : e;
    endfunction

    task automatic model_clear();
        m_step = 0; m_err = 0; m_first_v = 0; m_first = 0; m_sig = 16'hFFFF;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
        m_sig = sig_after_reset();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    // Holds valid low for gap cycles, then presents v for one accept.
    task automatic drive_sample(input logic [1:0] v, input int gap);
        sample_valid = 1'b0;
        repeat (gap) tick();
        sample_valid = 1'b1;
        {sample_x, sample_y} = v;
        n_cmp++;
        if (sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready step=%0d got ready=%b want 1", m_step, sample_ready);
        end
        tick();
        sample_valid = 1'b0;
        if (v != exp_pair(m_step)) begin
            m_err++;
            if (!m_first_v) begin m_first_v = 1; m_first = m_step; end
        end
        m_sig = misr_step(m_sig, v);
        m_step++;
    endtask

    task automatic check_final(input string tag);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_status got done=%b busy=%b ready=%b want 1 0 0", tag, done, busy, sample_ready);
        end
        n_cmp++;
        if (pass !== (m_err == 0)) begin
            n_bad++;
            $display("FAIL %s_pass got %b want %b", tag, pass, (m_err == 0));
        end
        n_cmp++;
        if (err_count !== CW'(sat_err(m_err))) begin
            n_bad++;
            $display("FAIL %s_err_count got %0d want %0d", tag, err_count, sat_err(m_err));
        end
        n_cmp++;
        if (first_err_valid !== m_first_v || (m_first_v && first_err_idx !== IW'(m_first))) begin
            n_bad++;
            $display("FAIL %s_first_err got v=%b idx=%0d want v=%b idx=%0d", tag, first_err_valid, first_err_idx, m_first_v, m_first);
        end
        n_cmp++;
        if (step_idx !== IW'(m_step) || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_step got step=%0d tmo=%b want %0d 0", tag, step_idx, timeout, m_step);
        end
        n_cmp++;
        if (signature !== sig_expected()) begin
            n_bad++;
            $display("FAIL %s_signature got %h want %h", tag, signature, sig_expected());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({busy, done, pass, timeout, sample_ready, first_err_valid} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000000", {busy, done, pass, timeout, sample_ready, first_err_valid});
        end
        n_cmp++;
        if (err_count !== '0 || first_err_idx !== '0 || step_idx !== '0) begin
            n_bad++;
            $display("FAIL reset_counts got err=%0d fei=%0d step=%0d want 0 0 0", err_count, first_err_idx, step_idx);
        end
        n_cmp++;
        if (signature !== sig_after_reset()) begin
            n_bad++;
            $display("FAIL reset_signature got %h want %h", signature, sig_after_reset());
        end
    endtask

    task automatic test_basic_pass();
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy got busy=%b ready=%b want 1 1", busy, sample_ready);
        end
        for (int k = 0; k < NSTEP; k++) begin
            drive_sample(exp_pair(k), 0);
            if (k == NSTEP - 2) begin
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL basic_not_done_early got done=%b busy=%b want 0 1", done, busy);
                end
            end
        end
        check_final("basic");
    endtask

    task automatic test_mismatches();
        pulse_start();
        for (int k = 0; k < NSTEP; k++) begin
            logic [1:0] v;
            v = exp_pair(k);
            if (k == 3 || k == 7) v = v ^ 2'b10;
            drive_sample(v, 0);
        end
        check_final("mismatch");
    endtask

    task automatic test_done_holds();
        int err_before;
        err_before = sat_err(m_err);
        sample_valid = 1'b1;
        {sample_x, sample_y} = ~exp_pair(0);
        repeat (3) tick();
        sample_valid = 1'b0;
        n_cmp++;
        if (sample_ready !== 1'b0 || done !== 1'b1 || err_count !== CW'(err_before) || step_idx !== IW'(NSTEP)) begin
            n_bad++;
            $display("FAIL done_hold got ready=%b done=%b err=%0d step=%0d want 0 1 %0d %0d", sample_ready, done, err_count, step_idx, err_before, NSTEP);
        end
    endtask

    task automatic test_timeout();
        int n;
        pulse_start();
        drive_sample(exp_pair(0), 0);
        drive_sample(exp_pair(1), 0);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != TMO) begin
            n_bad++;
            $display("FAIL timeout_latency got %0d cycles want %0d", n, TMO);
        end
        n_cmp++;
        if (timeout !== 1'b1 || pass !== 1'b0 || step_idx !== IW'(2) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_flags got tmo=%b pass=%b step=%0d busy=%b want 1 0 2 0", timeout, pass, step_idx, busy);
        end
        pulse_start();
        n_cmp++;
        if (timeout !== 1'b0 || busy !== 1'b1 || step_idx !== '0) begin
            n_bad++;
            $display("FAIL timeout_rearm got tmo=%b busy=%b step=%0d want 0 1 0", timeout, busy, step_idx);
        end
        apply_reset();
    endtask

    // An accept arriving on the cycle the idle limit is reached must win.
    task automatic test_idle_boundary();
        pulse_start();
        drive_sample(exp_pair(0), 0);
        drive_sample(exp_pair(1), TMO - 1);
        n_cmp++;
        if (busy !== 1'b1 || timeout !== 1'b0 || step_idx !== IW'(2)) begin
            n_bad++;
            $display("FAIL idle_boundary got busy=%b tmo=%b step=%0d want 1 0 2", busy, timeout, step_idx);
        end
        for (int k = 2; k < NSTEP; k++) drive_sample(exp_pair(k), TMO - 1);
        check_final("idle_boundary");
    endtask

    task automatic test_mid_reset();
        pulse_start();
        for (int k = 0; k < 5; k++) drive_sample(exp_pair(k) ^ 2'b01, 0);
        apply_reset();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || step_idx !== '0 || err_count !== '0 || first_err_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got busy=%b done=%b step=%0d err=%0d fev=%b want 0 0 0 0 0", busy, done, step_idx, err_count, first_err_valid);
        end
        pulse_start();
        for (int k = 0; k < NSTEP; k++) drive_sample(exp_pair(k), 0);
        check_final("after_reset");
    endtask

    task automatic test_start_in_run();
        pulse_start();
        for (int k = 0; k < 4; k++) drive_sample(exp_pair(k) ^ 2'b11, 0);
        pulse_start_keep_model();
        n_cmp++;
        if (step_idx !== IW'(4) || err_count !== CW'(3) || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_in_run got step=%0d err=%0d busy=%b want 4 3 1", step_idx, err_count, busy);
        end
        for (int k = 4; k < NSTEP; k++) drive_sample(exp_pair(k), 1);
        check_final("start_in_run");
    endtask

    task automatic pulse_start_keep_model();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_saturation_rearm();
        pulse_start();
        for (int k = 0; k < NSTEP; k++) drive_sample(~exp_pair(k), 0);
        check_final("saturation");
        test_done_holds();
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0 || step_idx !== '0 || signature !== sig_after_reset()) begin
            n_bad++;
            $display("FAIL rearm_clear got busy=%b done=%b err=%0d fev=%b step=%0d sig=%h", busy, done, err_count, first_err_valid, step_idx, signature);
        end
        for (int k = 0; k < NSTEP; k++) drive_sample(exp_pair(k), 0);
        check_final("rearm_clean");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            pulse_start();
            for (int k = 0; k < NSTEP; k++) begin
                logic [1:0] v;
                v = exp_pair(k);
                if ($urandom_range(0, 3) == 0) v = 2'($urandom_range(0, 3));
                drive_sample(v, $urandom_range(0, 3));
            end
            check_final("random");
        end
    endtask

`ifdef RESP_CHECKER_MISR_EN
    task automatic test_misr();
        logic [15:0] s1, s2, s3;
        pulse_start();
        for (int k = 0; k < NSTEP; k++) drive_sample(exp_pair(k), 0);
        s1 = signature;
        pulse_start();
        for (int k = 0; k < NSTEP; k++) drive_sample(exp_pair(k), 2);
        s2 = signature;
        pulse_start();
        for (int k = 0; k < NSTEP; k++) drive_sample((k == 4) ? exp_pair(k) ^ 2'b10 : exp_pair(k), 0);
        s3 = signature;
        n_cmp++;
        if (s1 !== s2) begin
            n_bad++;
            $display("FAIL misr_repeat got %h want %h", s2, s1);
        end
        n_cmp++;
        if (s3 === s1 || s3 !== m_sig) begin
            n_bad++;
            $display("FAIL misr_flip got %h want %h (differs from %h)", s3, m_sig, s1);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        exp_tab = EXP_TAB;
        model_clear();
        repeat (2) tick();
        test_reset();
        test_basic_pass();
        test_mismatches();
        test_done_holds();
        test_timeout();
        test_idle_boundary();
        test_mid_reset();
        test_start_in_run();
        test_saturation_rearm();
        test_random();
`ifdef RESP_CHECKER_MISR_EN
        test_misr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
